mult_div_unit: RTL and testbench
================================

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 Parameter: data_size, default 32, operand and HI/LO width; all counts below are stated for 32.
REQ-002 clk  input  1  single clock; all state changes on the rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  launch request from EX stage; sampled only when accepting (REQ-013).
REQ-005 op  input  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 src_a, src_b  input  data_size  forwarded EX operands (rs, rt) from the operand select muxes.
REQ-007 flush  input  1  pipeline flush; aborts any operation in progress.
REQ-008 hi_we, lo_we  input  1 each  MTHI / MTLO write enables.
REQ-009 wdata  input  data_size  MTHI/MTLO write data.
REQ-010 busy  output  1  operation in progress; the hazard logic stalls on MFHI/MFLO/start while it is high.
REQ-011 done  output  1  single-cycle pulse: HI/LO were updated by a completed operation.
REQ-012 hi, lo  output  data_size  architectural HI/LO registers, readable every cycle.

Function
REQ-013 FSM states: IDLE, CALC, FIX, DONE; start is accepted in IDLE or DONE, and is ignored in CALC/FIX.
REQ-014 Accepted start at edge k: latch op and operands, go to CALC, clear the 5-bit iteration counter, set busy.
REQ-015 CALC: one shift-add (multiply) or restoring shift-subtract (divide) step per edge on magnitudes; 32 steps on edges k+1..k+32; counter wrap 31->0 moves to FIX.
REQ-016 FIX (edge k+33): apply sign correction, write HI/LO, go to DONE; in that cycle busy=0 and done=1.
REQ-017 DONE returns to IDLE on the next edge unless start is accepted; done is never high for two consecutive cycles.
REQ-018 Multiply: {HI,LO} = full 64-bit product; MULT uses signed operands, MULTU unsigned.
REQ-019 Divide: LO = quotient and HI = remainder; signed quotient truncates toward zero and the remainder takes the dividend's sign.
REQ-020 Signed 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0x00000000.
REQ-021 Divide by zero: full latency, LO=0xFFFFFFFF, HI=src_a; this applies to both DIV and DIVU.
REQ-022 hi_we/lo_we: write wdata at the edge when state is IDLE or DONE; these writes are ignored while busy.
REQ-023 A write and a start on the same edge: the write takes effect, and the result of the launched operation later overwrites HI/LO.
REQ-024 flush in CALC/FIX: go to IDLE on the next edge, leave HI/LO unchanged, no done pulse; flush has priority over start.
REQ-025 Operands and op are held internally; changes on src_a/src_b/op after acceptance have no effect.

Reset
REQ-026 rst asserted: state=IDLE, counter=0, busy=0, done=0, hi=0, lo=0, all internal accumulators=0, immediately and independently of clk.
REQ-027 Reset mid-operation discards the operation; no done follows the release of reset.

Structure
REQ-028 Shared package mdu_pkg holds the op encodings, the state enum, and the constant MDU_ITER=32.
REQ-029 One sub-module is natural: mdu_fsm (state register, iteration counter, busy/done decode). The datapath (accumulator, shifter, sign fix) stays in mult_div_unit.

Verification
REQ-030 MULTU 7 x 6 -> done 33 cycles after the start edge; HI=0x00000000, LO=0x0000002A; busy high for exactly 33 cycles.
REQ-031 MULT 0xFFFFFFFD x 5 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1; MULTU of the same operands -> HI=0x00000004, LO=0xFFFFFFF1.
REQ-032 DIV 0xFFFFFFF9 / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 100 / 0 -> LO=0xFFFFFFFF, HI=0x00000064.
REQ-033 With HI=0x11, LO=0x22 preloaded via MTHI/MTLO, start DIV then flush at cycle 10 -> no done, HI/LO stay 0x11/0x22, a new start is accepted the next cycle.
REQ-034 start plus hi_we in CALC -> both ignored, result unchanged; start in the DONE cycle -> back-to-back operation, second done 33 cycles later.
REQ-035 rst asserted mid-CALC between edges -> busy, done, hi, lo all 0 immediately (no clock edge); no done after reset release.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared encodings and constants for the HI/LO multiply/divide unit.
package mdu_pkg;

  localparam int MDU_ITER = 32;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } mdu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_FIX,
    ST_DONE
  } mdu_state_e;

  function automatic logic op_is_signed(input mdu_op_e op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

  function automatic logic op_is_div(input mdu_op_e op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/mdu_fsm.sv
// Sequencer for the multiply/divide unit: state, iteration counter,
// and the load/step/commit strobes that drive the datapath.
module mdu_fsm
  import mdu_pkg::*;
#(
  parameter int ITER = MDU_ITER
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic flush,
  output logic load,
  output logic step,
  output logic commit,
  output logic busy,
  output logic done
);

  localparam int CW = $clog2(ITER);
  localparam logic [CW-1:0] LAST = CW'(ITER - 1);

  mdu_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // State and iteration counter registers.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: registers are written with <= so every flop samples the pre-edge values.
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state, counter and strobe decode; flush always wins over start.
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    step    = 1'b0;
    commit  = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (start && !flush) begin
          state_d = ST_CALC;
          cnt_d   = '0;
          load    = 1'b1;
        end
      end
      ST_CALC: begin
        if (flush) begin
          state_d = ST_IDLE;
        end else begin
          step  = 1'b1;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == LAST) state_d = ST_FIX;
        end
      end
      ST_FIX: begin
        if (flush) begin
          state_d = ST_IDLE;
        end else begin
          commit  = 1'b1;
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy = (state_q == ST_CALC) || (state_q == ST_FIX);
  assign done = (state_q == ST_DONE);

endmodule

// File: rtl/mult_div_unit.sv
// Iterative HI/LO multiply/divide unit: shift-add multiply and restoring
// divide on operand magnitudes, with sign correction applied on commit.
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int data_size = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [1:0]           op,
  input  logic [data_size-1:0] src_a,
  input  logic [data_size-1:0] src_b,
  input  logic                 flush,
  input  logic                 hi_we,
  input  logic                 lo_we,
  input  logic [data_size-1:0] wdata,
  output logic                 busy,
  output logic                 done,
  output logic [data_size-1:0] hi,
  output logic [data_size-1:0] lo
);

  localparam int W = data_size;

  logic load, step, commit;

  mdu_op_e      op_q, op_d;
  logic [W-1:0] a_q, a_d, b_q, b_d;
  logic [W-1:0] hi_q, hi_d, lo_q, lo_d;
  // Multiply: {partial product, remaining multiplier}. Divide: {remainder, quotient}.
  logic [2*W-1:0] acc_q, acc_d;

  logic           sgn, is_div;
  logic [W-1:0]   b_mag;
  logic [W:0]     mul_sum;
  logic [W:0]     div_shift;
  logic           div_ge;
  logic [W-1:0]   div_rem;
  logic [2*W-1:0] prod;
  logic [W-1:0]   quot, rem, res_hi, res_lo;

  function automatic logic [W-1:0] magnitude(input logic [W-1:0] v, input logic signed_op);
    return (signed_op && v[W-1]) ? -v : v;
  endfunction

  mdu_fsm #(.ITER(W)) u_fsm (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .flush  (flush),
    .load   (load),
    .step   (step),
    .commit (commit),
    .busy   (busy),
    .done   (done)
  );

  // Datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: operand and accumulator flops are reset too, so no stale operation survives rst.
    if (rst) begin
      op_q  <= OP_MULT;
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
    end else begin
      op_q  <= op_d;
      a_q   <= a_d;
      b_q   <= b_d;
      acc_q <= acc_d;
      hi_q  <= hi_d;
      lo_q  <= lo_d;
    end
  end

  // One iteration step: shift-add for multiply, restoring shift-subtract for divide.
  always_comb begin
    sgn       = op_is_signed(op_q);
    is_div    = op_is_div(op_q);
    b_mag     = magnitude(b_q, sgn);
    mul_sum   = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, b_mag} : '0);
    div_shift = {acc_q[2*W-1:W], acc_q[W-1]};
    div_ge    = (div_shift >= {1'b0, b_mag});
    div_rem   = div_ge ? (div_shift[W-1:0] - b_mag) : div_shift[W-1:0];
  end

  // Operand latch on acceptance and accumulator update.
  always_comb begin
    op_d  = op_q;
    a_d   = a_q;
    b_d   = b_q;
    acc_d = acc_q;
    if (load) begin
      op_d  = mdu_op_e'(op);
      a_d   = src_a;
      b_d   = src_b;
      acc_d = {{W{1'b0}}, magnitude(src_a, op_is_signed(mdu_op_e'(op)))};
    end else if (step) begin
      acc_d = is_div ? {div_rem, acc_q[W-2:0], div_ge}
                     : {mul_sum, acc_q[W-1:1]};
    end
  end

  // Sign correction of the finished magnitudes, including divide-by-zero.
  always_comb begin
    prod = acc_q;
    quot = acc_q[W-1:0];
    rem  = acc_q[2*W-1:W];
    if (sgn && (a_q[W-1] ^ b_q[W-1])) begin
      prod = -prod;
      quot = -quot;
    end
    if (sgn && a_q[W-1]) rem = -rem;
    if (b_q == '0) begin
      quot = '1;
      rem  = a_q;
    end
    res_hi = is_div ? rem  : prod[2*W-1:W];
    res_lo = is_div ? quot : prod[W-1:0];
  end

  // HI/LO update: completed result, or MTHI/MTLO when the unit is not busy.
  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (commit) begin
      hi_d = res_hi;
      lo_d = res_lo;
    end else if (!busy) begin
      if (hi_we) hi_d = wdata;
      if (lo_we) lo_d = wdata;
    end
  end

  assign hi = hi_q;
  assign lo = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit with hand-computed HI/LO results.
module tb_mult_div_unit;
  import mdu_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst, start, flush, hi_we, lo_we;
  logic [1:0]   op;
  logic [W-1:0] src_a, src_b, wdata;
  logic         busy, done;
  logic [W-1:0] hi, lo;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mult_div_unit #(.data_size(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op),
    .src_a (src_a),
    .src_b (src_b),
    .flush (flush),
    .hi_we (hi_we),
    .lo_we (lo_we),
    .wdata (wdata),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a start for one edge, then scramble the inputs the unit must have latched.
  task automatic launch(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    start = 1'b1;
    op    = o;
    src_a = a;
    src_b = b;
    tick();
    start = 1'b0;
    op    = ~o;
    src_a = ~a;
    src_b = b + W'(3);
  endtask

  // Edges until done is seen (bounded), and number of sampled cycles with busy high.
  task automatic wait_done(output int lat, output int bsy);
    lat = 0;
    bsy = busy ? 1 : 0;
    while (!done && lat < 100) begin
      tick();
      lat++;
      if (busy) bsy++;
    end
  endtask

  task automatic run(input string tag, input logic [1:0] o, input logic [W-1:0] a,
                     input logic [W-1:0] b, input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo);
    int lat, bsy;
    launch(o, a, b);
    wait_done(lat, bsy);
    check({tag, "_lat"}, lat, 33);
    check({tag, "_hi"}, hi, exp_hi);
    check({tag, "_lo"}, lo, exp_lo);
  endtask

  initial begin
    int lat, bsy, n_done;
    logic [W-1:0] hi_before;

    rst = 1'b1; start = 1'b0; flush = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    op = 2'b00; src_a = '0; src_b = '0; wdata = '0;
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    tick(); tick();
    rst = 1'b0;
    tick();

    // MULTU 7 x 6 with latency, busy length and single-cycle done.
    launch(OP_MULTU, 32'd7, 32'd6);
    wait_done(lat, bsy);
    check("multu7x6_lat", lat, 33);
    check("multu7x6_busy", bsy, 33);
    check("multu7x6_hi", hi, 32'h0000_0000);
    check("multu7x6_lo", lo, 32'h0000_002A);
    tick();
    check("done_one_cycle", done, 0);
    check("idle_after_done", busy, 0);

    run("mult_neg", OP_MULT, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
    run("multu_big", OP_MULTU, 32'hFFFF_FFFD, 32'd5, 32'h0000_0004, 32'hFFFF_FFF1);
    run("mult_minsq", OP_MULT, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
    run("div_neg", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run("div_negdiv", OP_DIV, 32'd7, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD);
    run("divu", OP_DIVU, 32'd100, 32'd7, 32'h0000_0002, 32'h0000_000E);
    run("divu_zero", OP_DIVU, 32'd100, 32'd0, 32'h0000_0064, 32'hFFFF_FFFF);
    run("div_zero", OP_DIV, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF);
    run("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);

    // MTHI/MTLO preload, then flush a DIV at the tenth cycle.
    hi_we = 1'b1; wdata = 32'h11; tick();
    hi_we = 1'b0; lo_we = 1'b1; wdata = 32'h22; tick();
    lo_we = 1'b0;
    check("mthi", hi, 32'h11);
    check("mtlo", lo, 32'h22);
    launch(OP_DIV, 32'd100, 32'd3);
    repeat (8) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_busy", busy, 0);
    check("flush_done", done, 0);
    check("flush_hi", hi, 32'h11);
    check("flush_lo", lo, 32'h22);
    launch(OP_MULTU, 32'd3, 32'd4);
    check("restart_busy", busy, 1);
    wait_done(lat, bsy);
    check("restart_lat", lat, 33);
    check("restart_lo", lo, 32'd12);

    // Flush beats a start presented in the DONE cycle.
    launch(OP_MULTU, 32'd2, 32'd2);
    wait_done(lat, bsy);
    start = 1'b1; flush = 1'b1; op = OP_MULTU; src_a = 32'd9; src_b = 32'd9;
    tick();
    start = 1'b0; flush = 1'b0;
    check("flush_prio_busy", busy, 0);
    check("flush_prio_lo", lo, 32'd4);

    // Start and MTHI while busy are ignored; then back-to-back from DONE.
    launch(OP_MULTU, 32'd9, 32'd9);
    repeat (5) tick();
    hi_before = hi;
    start = 1'b1; op = OP_DIVU; src_a = 32'd1000; src_b = 32'd3;
    hi_we = 1'b1; wdata = 32'hDEAD;
    tick();
    start = 1'b0; hi_we = 1'b0;
    check("busy_write_ignored", hi, hi_before);
    wait_done(lat, bsy);
    check("busy_start_lat", lat + 6, 33);
    check("busy_start_hi", hi, 32'd0);
    check("busy_start_lo", lo, 32'd81);
    launch(OP_MULTU, 32'd5, 32'd5);
    check("b2b_no_done", done, 0);
    wait_done(lat, bsy);
    check("b2b_lat", lat, 33);
    check("b2b_lo", lo, 32'd25);

    // MTHI/MTLO on the same edge as a start, later overwritten by the result.
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h55;
    launch(OP_MULTU, 32'd2, 32'd3);
    hi_we = 1'b0; lo_we = 1'b0;
    check("wr_start_hi", hi, 32'h55);
    check("wr_start_lo", lo, 32'h55);
    wait_done(lat, bsy);
    check("wr_start_res_hi", hi, 32'd0);
    check("wr_start_res_lo", lo, 32'd6);

    // Asynchronous reset in the middle of CALC.
    run("pre_rst", OP_MULTU, 32'hFFFF_FFFD, 32'd5, 32'h0000_0004, 32'hFFFF_FFF1);
    launch(OP_DIV, 32'd1000, 32'd7);
    repeat (4) tick();
    #2 rst = 1'b1;
    #1;
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_hi", hi, 0);
    check("arst_lo", lo, 0);
    tick(); tick();
    rst = 1'b0;
    n_done = 0;
    repeat (40) begin
      tick();
      if (done) n_done++;
    end
    check("arst_no_done", n_done, 0);
    check("arst_idle", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
